// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Sequential radix-2 Booth multiplier. Signed WIDTH x WIDTH operands give a
// signed 2*WIDTH-bit product. The controller FSM, iteration counter and the
// A/Y/Y-1 datapath are all in this one block.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (aborts any running operation)
//   start    request, only sampled while idle
//   x_in     multiplicand (two's complement), captured when start is accepted
//   y_in     multiplier (two's complement), captured when start is accepted
//   busy     high while iterating (ADD and SHIFT states)
//   done     one-cycle pulse when the result is ready
//   product  registered result, held until the next completion or reset
//
// Build option:
//   BOOTH_SKIP_EN  when defined, a 00/11 recode pair performs its shift in the
//                  ADD cycle itself, so SHIFT is only visited after 01/10 pairs.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} stateT;

  stateT state, nextState;

  logic signed [WIDTH-1:0]   xReg;
  logic signed [WIDTH-1:0]   yReg;
  // One guard bit so that A +/- X cannot overflow, even for X = -2^(WIDTH-1).
  logic signed [WIDTH:0]     aReg;
  logic                      ym1;
  logic [CNT_W-1:0]          cnt;

  logic [1:0]                pair;
  logic signed [WIDTH:0]     aNext;
  logic signed [2*WIDTH+1:0] shifted;
  logic                      lastIter;
  logic                      doShift;

  // Booth recode step: add, subtract or hold the sign-extended multiplicand.
  function automatic logic signed [WIDTH:0] recodeStep(
    input logic signed [WIDTH:0]   a,
    input logic signed [WIDTH-1:0] x,
    input logic [1:0]              p
  );
    logic signed [WIDTH:0] xs;
    xs = {x[WIDTH-1], x};
    case (p)
      2'b01:   return a + xs;
      2'b10:   return a - xs;
      default: return a;
    endcase
  endfunction

  // Arithmetic right shift of the concatenated {A, Y, Y-1} register.
  function automatic logic signed [2*WIDTH+1:0] asr1(
    input logic signed [2*WIDTH+1:0] v
  );
    return v >>> 1;
  endfunction

  always_comb begin
    pair     = {yReg[0], ym1};
    aNext    = recodeStep(aReg, xReg, pair);
    shifted  = asr1({aReg, yReg, ym1});
    lastIter = (cnt == CNT_W'(1));
`ifdef BOOTH_SKIP_EN
    // A 00/11 pair leaves A untouched, so its shift can happen right away.
    doShift  = (state == SHIFT) ||
               ((state == ADD) && ((pair == 2'b00) || (pair == 2'b11)));
`else
    doShift  = (state == SHIFT);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (doShift) nextState = lastIter ? DONE : ADD;
        else         nextState = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        nextState = lastIter ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operand capture, recode add/sub, shift/count, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      xReg    <= '0;
      yReg    <= '0;
      aReg    <= '0;
      ym1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xReg <= x_in;
            yReg <= y_in;
            aReg <= '0;
            ym1  <= 1'b0;
            cnt  <= CNT_W'(WIDTH);
          end
        end
        ADD, SHIFT: begin
          if (doShift) begin
            {aReg, yReg, ym1} <= shifted;
            cnt               <= cnt - CNT_W'(1);
            // Guard bit of A is dropped: the true product fits in 2*WIDTH bits.
            if (lastIter) product <= shifted[2*WIDTH:1];
          end else begin
            aReg <= aNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

  logic clk;
  logic rst;

  logic        start8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start2;
  logic [1:0]  x2, y2;
  logic        busy2, done2;
  logic [3:0]  prod2;

  logic        start16;
  logic [15:0] x16, y16;
  logic        busy16, done16;
  logic [31:0] prod16;

  int checks;
  int failures;

`ifdef BOOTH_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x_in(x8), .y_in(y8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_multiplier_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_in(x2), .y_in(y2),
    .busy(busy2), .done(done2), .product(prod2)
  );

  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .x_in(x16), .y_in(y16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
  } vecT;

  vecT vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Cycles from the accepting start edge to the edge that first samples done.
  function automatic int expLat(input logic [7:0] yv);
    int l;
    logic prev;
    l = 1;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l += (SKIP && (yv[i] == prev)) ? 1 : 2;
      prev = yv[i];
    end
    return l;
  endfunction

  task automatic op8(input logic [7:0] xv, input logic [7:0] yv,
                     output logic [15:0] p, output int lat);
    int n;
    @(posedge clk); #1;
    start8 = 1'b1; x8 = xv; y8 = yv;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    lat = (done8 === 1'b1) ? n + 1 : -1;
    p = prod8;
  endtask

  task automatic op2(input logic [1:0] xv, input logic [1:0] yv, output logic [3:0] p);
    int n;
    @(posedge clk); #1;
    start2 = 1'b1; x2 = xv; y2 = yv;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("w2_done", {63'd0, done2}, 64'd1);
    p = prod2;
  endtask

  task automatic op16(input logic [15:0] xv, input logic [15:0] yv, output logic [31:0] p);
    int n;
    @(posedge clk); #1;
    start16 = 1'b1; x16 = xv; y16 = yv;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (done16 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("w16_done", {63'd0, done16}, 64'd1);
    p = prod16;
  endtask

  initial begin
    logic [15:0] p8;
    logic [3:0]  p2;
    logic [31:0] p16;
    int lat;
    int n;
    int busyBad;
    int dn;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start8 = 1'b0;  x8 = '0;  y8 = '0;
    start2 = 1'b0;  x2 = '0;  y2 = '0;
    start16 = 1'b0; x16 = '0; y16 = '0;

    vecs[0]  = '{8'h03, 8'hFB, 16'hFFF1};
    vecs[1]  = '{8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{8'h7F, 8'h80, 16'hC080};
    vecs[3]  = '{8'h80, 8'h01, 16'hFF80};
    vecs[4]  = '{8'h00, 8'h00, 16'h0000};
    vecs[5]  = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[6]  = '{8'hFF, 8'hFF, 16'h0001};
    vecs[7]  = '{8'h05, 8'h07, 16'h0023};
    vecs[8]  = '{8'hFF, 8'h55, 16'hFFAB};
    vecs[9]  = '{8'h55, 8'hFF, 16'hFFAB};
    vecs[10] = '{8'h0C, 8'h00, 16'h0000};
    vecs[11] = '{8'hFD, 8'h09, 16'hFFE5};
    vecs[12] = '{8'h01, 8'h80, 16'hFF80};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy8}, 64'd0);
    check("reset_done", {63'd0, done8}, 64'd0);
    check("reset_prod8", {48'd0, prod8}, 64'd0);
    check("reset_prod2", {60'd0, prod2}, 64'd0);
    check("reset_prod16", {32'd0, prod16}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      op8(vecs[i].x, vecs[i].y, p8, lat);
      check($sformatf("vec%0d_prod", i), {48'd0, p8}, {48'd0, vecs[i].p});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(expLat(vecs[i].y)));
    end

    // start held high, operands changed while busy
    @(posedge clk); #1;
    start8 = 1'b1; x8 = 8'h03; y8 = 8'hFB;
    @(posedge clk); #1;
    x8 = 8'h02; y8 = 8'h03;
    check("held_busy_start", {63'd0, busy8}, 64'd1);
    n = 0;
    busyBad = 0;
    while (done8 !== 1'b1 && n < 200) begin
      if (busy8 !== 1'b1) busyBad++;
      @(posedge clk); #1;
      n++;
    end
    check("held_latency", 64'(n + 1), 64'(expLat(8'hFB)));
    check("held_prod", {48'd0, prod8}, 64'h0000_0000_0000_FFF1);
    check("held_busy_gap", 64'(busyBad), 64'd0);
    check("held_done_busy", {63'd0, busy8}, 64'd0);
    @(posedge clk); #1;
    check("held_done_pulse", {63'd0, done8}, 64'd0);
    check("held_idle_busy", {63'd0, busy8}, 64'd0);
    @(posedge clk); #1;
    check("held_restart_busy", {63'd0, busy8}, 64'd1);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_second_prod", {48'd0, prod8}, 64'd6);

    // reset in the middle of an operation
    @(posedge clk); #1;
    start8 = 1'b1; x8 = 8'h07; y8 = 8'h09;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", {63'd0, busy8}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {63'd0, busy8}, 64'd0);
    check("abort_done", {63'd0, done8}, 64'd0);
    check("abort_prod", {48'd0, prod8}, 64'd0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) dn++;
    end
    check("abort_no_activity", 64'(dn), 64'd0);
    op8(8'h07, 8'h09, p8, lat);
    check("abort_fresh_prod", {48'd0, p8}, 64'h3F);
    check("abort_fresh_latency", 64'(lat), 64'(expLat(8'h09)));

    // WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        logic signed [1:0] sa, sb;
        logic signed [3:0] e;
        sa = 2'(a);
        sb = 2'(b);
        e = sa * sb;
        op2(sa, sb, p2);
        check($sformatf("w2_%0d_%0d", a, b), {60'd0, p2}, {60'd0, e});
      end
    end

    // WIDTH=16 signed sweep, extremes first
    for (int i = 0; i < 1000; i++) begin
      logic signed [15:0] sa, sb;
      logic signed [31:0] e;
      if (i == 0) begin
        sa = 16'sh8000; sb = 16'sh8000;
      end else if (i == 1) begin
        sa = 16'sh7FFF; sb = 16'sh8000;
      end else begin
        sa = 16'($urandom);
        sb = 16'($urandom);
      end
      e = sa * sb;
      op16(sa, sb, p16);
      check($sformatf("w16_%0d", i), {32'd0, p16}, {32'd0, e});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
